dense_argmax: RTL and testbench
===============================

Name: dense_argmax

Overview:
- Fully-connected output layer of the CNN. It sits directly downstream of the flattening stage.
- Streams in the flattened pooled feature vector one element per handshake. For each class it accumulates a ternary-weighted dot product, then runs a sequential argmax.
- Presents the winning class index and its score on a valid/ready output.
- Weights live in an internal register memory loaded through a write port, in the same way as the feature memory.

Parameters:
- FLATTENED_LENGTH, 50, input vector length (12x12 image, 3x3 kernel, 2x2 pool, 2 features).
- NUM_CLASSES, 4, number of output neurons.
- DATA_WIDTH, 8, signed width of input elements.
- WEIGHT_WIDTH, 2, signed weight width; legal values are -1, 0, +1.
- ACC_WIDTH, DATA_WIDTH+$clog2(FLATTENED_LENGTH)+1, signed accumulator and score width.

Ports:
- clk  in  1  rising-edge clock for all state.
- rst_dense  in  1  asynchronous, active-low reset of datapath and FSM.
- rst_weights  in  1  asynchronous, active-low reset; clears all weights to 0.
- weight_wr_en  in  1  weight write strobe, active high.
- weight_class  in  $clog2(NUM_CLASSES)  class address for a weight write.
- weight_index  in  $clog2(FLATTENED_LENGTH)  element address for a weight write.
- weight_data  in  WEIGHT_WIDTH  signed weight value.
- in_valid  in  1  input element valid.
- in_ready  out  1  block can accept an element.
- in_data  in  DATA_WIDTH  signed flattened element.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_class  out  $clog2(NUM_CLASSES)  argmax class index.
- out_score  out  ACC_WIDTH  signed winning accumulator value.

Behaviour:
- Reset is asynchronous, active-low, on one clock (clk).
- On rst_dense low:
  - state goes to IDLE; element counter, argmax counter and all accumulators go to 0.
  - out_valid=0, out_class=0, out_score=0; in_ready=0 while reset is asserted.
  - weights are untouched by rst_dense.
- rst_weights low clears every weight to 0 and does not disturb the FSM.
- A reset asserted mid-stream or mid-argmax aborts the inference. The next inference starts clean with no residue.
- FSM states are IDLE, ACCUMULATE, ARGMAX, OUTPUT.
- IDLE:
  - in_ready=1.
  - Weight writes are accepted only in IDLE and are ignored in every other state.
  - On an in_valid&&in_ready handshake: acc[c] = in_data*w[c][0] for all c, so accumulators are overwritten, not added. The counter is set to 1 and the state moves to ACCUMULATE.
  - A weight write and an input accept to the same address in the same cycle: the product uses the old weight value.
- ACCUMULATE:
  - in_ready=1.
  - Each handshake adds in_data*w[c][count] to acc[c] for all classes in parallel.
  - Products are sign-extended to ACC_WIDTH. Because weights are ternary, each product is a negate, zero or pass-through, with no multiplier.
  - No overflow is possible by construction.
  - Cycles without in_valid hold all state.
  - The handshake on element FLATTENED_LENGTH-1 moves the state to ARGMAX.
  - FLATTENED_LENGTH=1 goes directly from IDLE to ARGMAX.
- ARGMAX:
  - in_ready=0.
  - Runs NUM_CLASSES cycles, k=0..NUM_CLASSES-1. Cycle 0 loads best=acc[0], idx=0. Later cycles replace best only on strictly greater, so ties resolve to the lowest index.
  - After the last compare the state moves to OUTPUT.
- OUTPUT:
  - out_valid=1; out_class and out_score are registered and stable until the handshake; in_ready=0.
  - On out_valid&&out_ready: out_valid drops and the state moves to IDLE on the next edge.
- Latency: last input accepted at edge T gives out_valid=1 after edge T+NUM_CLASSES+1.
- With out_ready held high, a new stream can be accepted 1 cycle after the output handshake.

Decomposition:
- Shared package cnn_pkg holds:
  - the state typedef enum {IDLE, ACCUMULATE, ARGMAX, OUTPUT}, alongside the existing CNN top-level state encoding;
  - the FLATTENED_LENGTH derivation constants;
  - the ternary weight typedef.
- One natural sub-module, dense_weight_mem. It is a NUM_CLASSES x FLATTENED_LENGTH register array with:
  - a single write port;
  - a combinational read of one full column (all classes at one index);
  - asynchronous clear.

Test Plan:
1. Weights at zero: rst_weights pulse, stream 50 elements of 5 -> all scores 0, out_class=0, out_score=0; out_valid rises 5 cycles after the last accept.
2. Class 2 all +1, others 0, stream 50 elements of 3 -> out_class=2, out_score=150.
3. Class 0 all -1, class 1 all +1, stream 50 elements of -2 -> out_class=0, out_score=100.
4. Extreme values: class 3 all -1, others +1, stream 50 elements of -128 -> out_class=3, out_score=6400, no wrap.
5. Backpressure:
   - in_valid toggled every other cycle -> same result as a continuous stream.
   - out_ready low for 10 cycles -> outputs stable, in_ready=0, weight writes ignored.
   - Then IDLE one cycle after out_ready.
6. Reset mid-operation: rst_dense low after 20 elements, then a full 50-element stream as in test 2 -> identical result (class 2, score 150), with weights retained.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN definitions: controller state encodings, geometry that fixes the
// flattened vector length, and the ternary weight type.
package cnn_pkg;

  typedef enum logic [2:0] {
    CNN_IDLE, CNN_CONV, CNN_POOL, CNN_FLATTEN, CNN_DENSE, CNN_DONE
  } cnn_state_t;

  typedef enum logic [1:0] {IDLE, ACCUMULATE, ARGMAX, OUTPUT} dense_state_t;

  localparam int IMAGE_SIZE    = 12;
  localparam int KERNEL_SIZE   = 3;
  localparam int POOL_SIZE     = 2;
  localparam int NUM_FEATURES  = 2;
  localparam int CONV_OUT_SIZE = IMAGE_SIZE - KERNEL_SIZE + 1;
  localparam int POOL_OUT_SIZE = CONV_OUT_SIZE / POOL_SIZE;
  localparam int FLAT_LEN      = POOL_OUT_SIZE * POOL_OUT_SIZE * NUM_FEATURES;

  localparam int TERNARY_W = 2;
  typedef logic signed [TERNARY_W-1:0] ternary_t;

  // Address width that never collapses to zero bits for single-entry ranges.
  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dense_weight_mem.sv
// Ternary weight store: one write port, combinational read of a full column
// (every class at one element index), asynchronous clear.
module dense_weight_mem
  import cnn_pkg::*;
#(
  parameter int NUM_CLASSES      = 4,
  parameter int FLATTENED_LENGTH = FLAT_LEN,
  parameter int WEIGHT_WIDTH     = TERNARY_W,
  localparam int CLS_W           = safe_clog2(NUM_CLASSES),
  localparam int IDX_W           = safe_clog2(FLATTENED_LENGTH)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   wr_en,
  input  logic [CLS_W-1:0]                       wr_class,
  input  logic [IDX_W-1:0]                       wr_index,
  input  logic signed [WEIGHT_WIDTH-1:0]         wr_data,
  input  logic [IDX_W-1:0]                       rd_index,
  output logic [NUM_CLASSES-1:0][WEIGHT_WIDTH-1:0] rd_col
);

  logic [WEIGHT_WIDTH-1:0] mem [NUM_CLASSES][FLATTENED_LENGTH];

  // Address decode by comparison so out-of-range writes fall through harmlessly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CLASSES; c++)
        for (int i = 0; i < FLATTENED_LENGTH; i++)
          mem[c][i] <= '0;
    end else if (wr_en) begin
      for (int c = 0; c < NUM_CLASSES; c++)
        for (int i = 0; i < FLATTENED_LENGTH; i++)
          if (wr_class == CLS_W'(c) && wr_index == IDX_W'(i))
            mem[c][i] <= wr_data;
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CLASSES; c++)
      rd_col[c] = mem[c][rd_index];
  end

endmodule

// File: rtl/dense_argmax.sv
// Fully-connected output layer: ternary-weighted dot product per class over a
// streamed feature vector, then a sequential argmax presented on valid/ready.
module dense_argmax
  import cnn_pkg::*;
#(
  parameter int FLATTENED_LENGTH = FLAT_LEN,
  parameter int NUM_CLASSES      = 4,
  parameter int DATA_WIDTH       = 8,
  parameter int WEIGHT_WIDTH     = TERNARY_W,
  parameter int ACC_WIDTH        = DATA_WIDTH + $clog2(FLATTENED_LENGTH) + 1,
  localparam int CLS_W           = safe_clog2(NUM_CLASSES),
  localparam int IDX_W           = safe_clog2(FLATTENED_LENGTH)
) (
  input  logic                           clk,
  input  logic                           rst_dense,
  input  logic                           rst_weights,
  input  logic                           weight_wr_en,
  input  logic [CLS_W-1:0]               weight_class,
  input  logic [IDX_W-1:0]               weight_index,
  input  logic signed [WEIGHT_WIDTH-1:0] weight_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [DATA_WIDTH-1:0]   in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CLS_W-1:0]               out_class,
  output logic signed [ACC_WIDTH-1:0]    out_score
);

  localparam int ACNT_W = $clog2(NUM_CLASSES + 1);

  dense_state_t state, state_nxt;
  logic alive;
  logic [IDX_W-1:0] elem_cnt;
  logic [ACNT_W-1:0] amax_cnt;
  logic signed [ACC_WIDTH-1:0] acc [NUM_CLASSES];
  logic signed [ACC_WIDTH-1:0] best;
  logic [CLS_W-1:0] best_idx;
  logic [NUM_CLASSES-1:0][WEIGHT_WIDTH-1:0] w_col;
  logic accept, last_elem, amax_done;

  // Ternary weights reduce the multiply to negate / zero / pass-through.
  function automatic logic signed [ACC_WIDTH-1:0] ternary_mul(
    input logic signed [DATA_WIDTH-1:0]   x,
    input logic signed [WEIGHT_WIDTH-1:0] w
  );
    logic signed [ACC_WIDTH-1:0] xe;
    xe = {{(ACC_WIDTH-DATA_WIDTH){x[DATA_WIDTH-1]}}, x};
    if (w == WEIGHT_WIDTH'(1))  return xe;
    else if (w == '1)           return -xe;
    else                        return '0;
  endfunction

  assign accept    = in_valid && in_ready;
  assign last_elem = (elem_cnt == IDX_W'(FLATTENED_LENGTH - 1));
  assign amax_done = (amax_cnt == ACNT_W'(NUM_CLASSES));

  dense_weight_mem #(
    .NUM_CLASSES     (NUM_CLASSES),
    .FLATTENED_LENGTH(FLATTENED_LENGTH),
    .WEIGHT_WIDTH    (WEIGHT_WIDTH)
  ) u_weight_mem (
    .clk     (clk),
    .rst_n   (rst_weights),
    .wr_en   (weight_wr_en && state == IDLE),
    .wr_class(weight_class),
    .wr_index(weight_index),
    .wr_data (weight_data),
    .rd_index(elem_cnt),
    .rd_col  (w_col)
  );

  // alive keeps in_ready low until the first edge after rst_dense releases.
  always_ff @(posedge clk or negedge rst_dense) begin
    if (!rst_dense) begin
      state <= IDLE;
      alive <= 1'b0;
    end else begin
      state <= state_nxt;
      alive <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (accept) state_nxt = last_elem ? ARGMAX : ACCUMULATE;
      ACCUMULATE: if (accept && last_elem) state_nxt = ARGMAX;
      ARGMAX:     if (amax_done) state_nxt = OUTPUT;
      OUTPUT:     if (out_ready) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE, ACCUMULATE: in_ready  = alive;
      OUTPUT:           out_valid = 1'b1;
      default:          ;
    endcase
  end

  // Accumulate / argmax datapath; the extra argmax step commits best to the outputs.
  always_ff @(posedge clk or negedge rst_dense) begin
    if (!rst_dense) begin
      elem_cnt  <= '0;
      amax_cnt  <= '0;
      best      <= '0;
      best_idx  <= '0;
      out_class <= '0;
      out_score <= '0;
      for (int c = 0; c < NUM_CLASSES; c++) acc[c] <= '0;
    end else begin
      case (state)
        IDLE, ACCUMULATE: begin
          if (accept) begin
            for (int c = 0; c < NUM_CLASSES; c++)
              acc[c] <= ((state == IDLE) ? '0 : acc[c]) + ternary_mul(in_data, $signed(w_col[c]));
            elem_cnt <= last_elem ? '0 : elem_cnt + IDX_W'(1);
          end
        end
        ARGMAX: begin
          if (amax_done) begin
            out_class <= best_idx;
            out_score <= best;
            amax_cnt  <= '0;
          end else begin
            if (amax_cnt == '0) begin
              best     <= acc[0];
              best_idx <= '0;
            end else if (acc[amax_cnt[CLS_W-1:0]] > best) begin
              best     <= acc[amax_cnt[CLS_W-1:0]];
              best_idx <= amax_cnt[CLS_W-1:0];
            end
            amax_cnt <= amax_cnt + ACNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_argmax.sv
// Randomised and directed bench for dense_argmax against a plain dot-product /
// argmax reference model.
module tb_dense_argmax;

  localparam int FL = 50;
  localparam int NC = 4;
  localparam int DW = 8;
  localparam int WW = 2;
  localparam int AW = DW + $clog2(FL) + 1;

  logic                 clk = 1'b0;
  logic                 rst_dense, rst_weights;
  logic                 weight_wr_en;
  logic [1:0]           weight_class;
  logic [5:0]           weight_index;
  logic signed [WW-1:0] weight_data;
  logic                 in_valid, in_ready;
  logic signed [DW-1:0] in_data;
  logic                 out_valid, out_ready;
  logic [1:0]           out_class;
  logic signed [AW-1:0] out_score;

  always #5 clk = ~clk;

  dense_argmax #(
    .FLATTENED_LENGTH(FL),
    .NUM_CLASSES     (NC),
    .DATA_WIDTH      (DW),
    .WEIGHT_WIDTH    (WW)
  ) dut (
    .clk         (clk),
    .rst_dense   (rst_dense),
    .rst_weights (rst_weights),
    .weight_wr_en(weight_wr_en),
    .weight_class(weight_class),
    .weight_index(weight_index),
    .weight_data (weight_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_class   (out_class),
    .out_score   (out_score)
  );

  int n_cmp = 0;
  int n_mis = 0;
  int w_model [NC][FL];
  int xs [FL];

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_weight(input int c, input int i, input int v);
    weight_wr_en = 1'b1;
    weight_class = 2'(c);
    weight_index = 6'(i);
    weight_data  = 2'(v);
    tick();
    weight_wr_en = 1'b0;
  endtask

  task automatic load_all();
    for (int c = 0; c < NC; c++)
      for (int i = 0; i < FL; i++)
        write_weight(c, i, w_model[c][i]);
  endtask

  task automatic set_model(input int c, input int v);
    for (int i = 0; i < FL; i++) w_model[c][i] = v;
  endtask

  task automatic set_data(input int v);
    for (int i = 0; i < FL; i++) xs[i] = v;
  endtask

  // Reference: plain dot products, first maximum wins.
  task automatic expected(output int cls, output int score);
    int s [NC];
    for (int c = 0; c < NC; c++) begin
      s[c] = 0;
      for (int i = 0; i < FL; i++) s[c] += xs[i] * w_model[c][i];
    end
    cls = 0;
    score = s[0];
    for (int c = 1; c < NC; c++)
      if (s[c] > score) begin
        cls = c;
        score = s[c];
      end
  endtask

  // gaps: 0 continuous, 1 alternating, 2 random. coll_c >= 0 writes coll_v to
  // weight (coll_c, 0) in the same cycle as the first accept.
  task automatic run_stream(input string tag, input int gaps, input int hold,
                            input int coll_c, input int coll_v);
    int ecls, escore, i, cyc, lat;
    bit acc_now;
    expected(ecls, escore);
    i = 0;
    cyc = 0;
    while (i < FL && cyc < 2000) begin
      case (gaps)
        0:       in_valid = 1'b1;
        1:       in_valid = (cyc % 2 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = 8'(xs[i]);
      if (coll_c >= 0 && cyc == 0) begin
        weight_wr_en = 1'b1;
        weight_class = 2'(coll_c);
        weight_index = 6'd0;
        weight_data  = 2'(coll_v);
      end
      @(negedge clk);
      acc_now = in_valid && in_ready;
      tick();
      weight_wr_en = 1'b0;
      if (acc_now) i++;
      cyc++;
    end
    in_valid = 1'b0;
    check({tag, "/accepted"}, i, FL);
    if (coll_c >= 0) w_model[coll_c][0] = coll_v;

    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    check({tag, "/latency"}, lat, NC + 1);
    check({tag, "/class"}, out_class, ecls);
    check({tag, "/score"}, $signed(out_score), escore);

    for (int k = 0; k < hold; k++) begin
      weight_wr_en = 1'b1;
      weight_class = 2'd2;
      weight_index = 6'(k);
      weight_data  = 2'b11;
      tick();
      check({tag, "/hold_valid"}, out_valid, 1);
      check({tag, "/hold_ready"}, in_ready, 0);
      check({tag, "/hold_class"}, out_class, ecls);
      check({tag, "/hold_score"}, $signed(out_score), escore);
    end
    weight_wr_en = 1'b0;

    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "/post_valid"}, out_valid, 0);
    check({tag, "/post_ready"}, in_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_dense    = 1'b0;
    rst_weights  = 1'b0;
    weight_wr_en = 1'b0;
    weight_class = '0;
    weight_index = '0;
    weight_data  = '0;
    in_valid     = 1'b0;
    in_data      = '0;
    out_ready    = 1'b0;
    for (int c = 0; c < NC; c++) set_model(c, 0);

    repeat (3) tick();
    check("reset/in_ready", in_ready, 0);
    check("reset/out_valid", out_valid, 0);
    check("reset/out_class", out_class, 0);
    check("reset/out_score", $signed(out_score), 0);
    rst_dense   = 1'b1;
    rst_weights = 1'b1;
    repeat (2) tick();
    check("reset/idle_ready", in_ready, 1);

    // Test 1: stale weights cleared by rst_weights, ties resolve to class 0.
    for (int i = 0; i < 5; i++) write_weight(1, i, 1);
    rst_weights = 1'b0;
    tick();
    rst_weights = 1'b1;
    tick();
    set_data(5);
    run_stream("t1_zero", 0, 0, -1, 0);

    // Test 2: class 2 all +1; colliding write uses the old weight this pass.
    set_model(2, 1);
    load_all();
    set_data(3);
    run_stream("t2_pos", 0, 0, 2, 0);

    // Test 5: alternating valid, held output with ignored writes, then rerun.
    run_stream("t5_gaps", 1, 10, -1, 0);
    run_stream("t5_rerun", 0, 0, -1, 0);

    // Test 3
    set_model(0, -1);
    set_model(1, 1);
    set_model(2, 0);
    set_model(3, 0);
    load_all();
    set_data(-2);
    run_stream("t3_neg", 0, 0, -1, 0);

    // Test 4: extreme magnitude
    set_model(0, 1);
    set_model(1, 1);
    set_model(2, 1);
    set_model(3, -1);
    load_all();
    set_data(-128);
    run_stream("t4_ext", 0, 0, -1, 0);

    // Test 6: reset after 20 elements, weights survive, next run is clean.
    set_model(0, 0);
    set_model(1, 0);
    set_model(2, 1);
    set_model(3, 0);
    load_all();
    set_data(3);
    in_valid = 1'b1;
    in_data  = 8'sd7;
    repeat (20) tick();
    in_valid  = 1'b0;
    rst_dense = 1'b0;
    #1;
    check("t6/rst_ready", in_ready, 0);
    check("t6/rst_valid", out_valid, 0);
    check("t6/rst_score", $signed(out_score), 0);
    tick();
    rst_dense = 1'b1;
    repeat (2) tick();
    run_stream("t6_after", 0, 0, -1, 0);

    // Randomised weights, data, valid gaps and output backpressure.
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < NC; c++)
        for (int i = 0; i < FL; i++)
          w_model[c][i] = int'($urandom_range(0, 2)) - 1;
      for (int i = 0; i < FL; i++) xs[i] = int'($urandom_range(0, 255)) - 128;
      load_all();
      run_stream($sformatf("rand%0d", r), 2, int'($urandom_range(0, 3)), -1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
